// File: rtl/ysyx_25060173_alu_seq_pkg.sv
// Shared op-code map and FSM encodings for the sequential execute ALU.
// Ops 10-14 are live only when YSYX_25060173_ALU_MDU_EN is defined.
package ysyx_25060173_alu_seq_pkg;

  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OPW-1:0] ALU_OP_SUB  = 4'd1;
  localparam logic [ALU_OPW-1:0] ALU_OP_SLL  = 4'd2;
  localparam logic [ALU_OPW-1:0] ALU_OP_SLT  = 4'd3;
  localparam logic [ALU_OPW-1:0] ALU_OP_SLTU = 4'd4;
  localparam logic [ALU_OPW-1:0] ALU_OP_XOR  = 4'd5;
  localparam logic [ALU_OPW-1:0] ALU_OP_SRL  = 4'd6;
  localparam logic [ALU_OPW-1:0] ALU_OP_SRA  = 4'd7;
  localparam logic [ALU_OPW-1:0] ALU_OP_OR   = 4'd8;
  localparam logic [ALU_OPW-1:0] ALU_OP_AND  = 4'd9;
  localparam logic [ALU_OPW-1:0] ALU_OP_MUL  = 4'd10;
  localparam logic [ALU_OPW-1:0] ALU_OP_DIV  = 4'd11;
  localparam logic [ALU_OPW-1:0] ALU_OP_DIVU = 4'd12;
  localparam logic [ALU_OPW-1:0] ALU_OP_REM  = 4'd13;
  localparam logic [ALU_OPW-1:0] ALU_OP_REMU = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    MDU_MUL = 2'd0,
    MDU_DIV = 2'd1,
    MDU_REM = 2'd2
  } mdu_kind_e;

endpackage

// File: rtl/ysyx_25060173_mdu_iter.sv
// Iterative multiply/divide: one shift-add or restoring-subtract step per cycle.
// Only instantiated when YSYX_25060173_ALU_MDU_EN is defined.
module ysyx_25060173_mdu_iter
  import ysyx_25060173_alu_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = ALU_OPW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  mdu_kind_e       kind_q, kind_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] acc_q, sh_q, opd_q;
  logic [XLEN-1:0] acc_n, sh_n, opd_n;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   r_sh, diff;
  logic            sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, raw;

  assign sgn   = (op == ALU_OP_DIV) | (op == ALU_OP_REM);
  assign a_neg = sgn & src1[XLEN-1];
  assign b_neg = sgn & src2[XLEN-1];
  assign a_mag = a_neg ? -src1 : src1;
  assign b_mag = b_neg ? -src2 : src2;

  // Quotient takes the xor of signs; remainder follows the dividend.
  always_comb begin
    kind_d = MDU_MUL;
    neg_d  = 1'b0;
    case (op)
      ALU_OP_DIV, ALU_OP_DIVU: begin
        kind_d = MDU_DIV;
        neg_d  = a_neg ^ b_neg;
      end
      ALU_OP_REM, ALU_OP_REMU: begin
        kind_d = MDU_REM;
        neg_d  = a_neg;
      end
      default: ;
    endcase
  end

  // acc: product / partial remainder; sh: multiplier / dividend->quotient; opd: multiplicand / divisor
  always_comb begin
    r_sh  = {acc_q, sh_q[XLEN-1]};
    diff  = r_sh - {1'b0, opd_q};
    acc_n = acc_q;
    sh_n  = sh_q;
    opd_n = opd_q;
    if (kind_q == MDU_MUL) begin
      acc_n = acc_q + (sh_q[0] ? opd_q : '0);
      sh_n  = sh_q >> 1;
      opd_n = opd_q << 1;
    end else begin
      acc_n = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      sh_n  = {sh_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

  // Last step result is taken straight from the next-state values.
  assign raw    = (kind_q == MDU_DIV) ? sh_n : acc_n;
  assign result = neg_q ? -raw : raw;
  assign done   = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= MDU_MUL;
      neg_q  <= 1'b0;
      acc_q  <= '0;
      sh_q   <= '0;
      opd_q  <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (start) begin
      kind_q <= kind_d;
      neg_q  <= neg_d;
      acc_q  <= '0;
      sh_q   <= (kind_d == MDU_MUL) ? src2 : a_mag;
      opd_q  <= (kind_d == MDU_MUL) ? src1 : b_mag;
      cnt_q  <= CW'(XLEN);
    end else if (cnt_q != '0) begin
      acc_q <= acc_n;
      sh_q  <= sh_n;
      opd_q <= opd_n;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/ysyx_25060173_alu_seq.sv
// Sequential execute ALU: registered simple ops, optional iterative MUL/DIV/REM.
// Define YSYX_25060173_ALU_MDU_EN to build the multiply/divide unit.
module ysyx_25060173_alu_seq
  import ysyx_25060173_alu_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = ALU_OPW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, fast_res, mdu_res;
  logic            illegal_q, fast_ill;
  logic            accept, mdu_start, mdu_done;
  logic [SHW-1:0]  shamt;

  assign in_ready    = (state_q == ST_IDLE);
  assign accept      = in_valid & in_ready & ~flush;
  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = result_q;
  assign out_illegal = illegal_q;
  assign shamt       = in_src2[SHW-1:0];

`ifdef YSYX_25060173_ALU_MDU_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic div0, ovf;
  assign div0 = (in_src2 == '0);
  assign ovf  = (in_src1 == MIN_NEG) & (in_src2 == '1);
`endif

  // Anything not routed to the MDU finishes here in one cycle.
  always_comb begin
    fast_res  = '0;
    fast_ill  = 1'b0;
    mdu_start = 1'b0;
    case (in_op)
      ALU_OP_ADD:  fast_res = in_src1 + in_src2;
      ALU_OP_SUB:  fast_res = in_src1 - in_src2;
      ALU_OP_SLL:  fast_res = in_src1 << shamt;
      ALU_OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(in_src1) < $signed(in_src2)};
      ALU_OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, in_src1 < in_src2};
      ALU_OP_XOR:  fast_res = in_src1 ^ in_src2;
      ALU_OP_SRL:  fast_res = in_src1 >> shamt;
      ALU_OP_SRA:  fast_res = $unsigned($signed(in_src1) >>> shamt);
      ALU_OP_OR:   fast_res = in_src1 | in_src2;
      ALU_OP_AND:  fast_res = in_src1 & in_src2;
`ifdef YSYX_25060173_ALU_MDU_EN
      ALU_OP_MUL:  mdu_start = accept;
      ALU_OP_DIV: begin
        if (div0)     fast_res = '1;
        else if (ovf) fast_res = in_src1;
        else          mdu_start = accept;
      end
      ALU_OP_DIVU: begin
        if (div0) fast_res = '1;
        else      mdu_start = accept;
      end
      ALU_OP_REM: begin
        if (div0)     fast_res = in_src1;
        else if (ovf) fast_res = '0;
        else          mdu_start = accept;
      end
      ALU_OP_REMU: begin
        if (div0) fast_res = in_src1;
        else      mdu_start = accept;
      end
`endif
      default:     fast_ill = 1'b1;
    endcase
  end

`ifdef YSYX_25060173_ALU_MDU_EN
  ysyx_25060173_mdu_iter #(
    .XLEN (XLEN),
    .OPW  (OPW)
  ) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (mdu_start),
    .op     (in_op),
    .src1   (in_src1),
    .src2   (in_src2),
    .done   (mdu_done),
    .result (mdu_res)
  );
`else
  assign mdu_done = 1'b0;
  assign mdu_res  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // flush outranks both accept and the output handshake
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept)    state_d = mdu_start ? ST_BUSY : ST_DONE;
        ST_BUSY: if (mdu_done)  state_d = ST_DONE;
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default:                state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (!flush) begin
      if (accept && !mdu_start) begin
        result_q  <= fast_res;
        illegal_q <= fast_ill;
      end else if (state_q == ST_BUSY && mdu_done) begin
        result_q  <= mdu_res;
        illegal_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_alu_seq.sv
// Scoreboard bench for ysyx_25060173_alu_seq; expectations follow YSYX_25060173_ALU_MDU_EN.
module tb_ysyx_25060173_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  ysyx_25060173_alu_seq #(.XLEN(32), .OPW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input string name, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb_;
    logic [63:0] p;
    logic mdu_on, special;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    p = 64'(a) * 64'(b);
`ifdef YSYX_25060173_ALU_MDU_EN
    mdu_on = 1'b1;
`else
    mdu_on = 1'b0;
`endif
    e.name = name;
    e.res = '0;
    e.ill = 1'b0;
    e.lat = 1;
    special = (b == 0) || ((op == 11 || op == 13) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    case (op)
      0:  e.res = a + b;
      1:  e.res = a - b;
      2:  e.res = a << b[4:0];
      3:  e.res = (sa < sb_) ? 32'd1 : 32'd0;
      4:  e.res = (a < b) ? 32'd1 : 32'd0;
      5:  e.res = a ^ b;
      6:  e.res = a >> b[4:0];
      7:  e.res = $signed(a) >>> b[4:0];
      8:  e.res = a | b;
      9:  e.res = a & b;
      10: e.res = p[31:0];
      11: e.res = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb_);
      12: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: e.res = (b == 0) ? a : 32'(sa % sb_);
      14: e.res = (b == 0) ? a : a % b;
      default: e.ill = 1'b1;
    endcase
    if (op >= 10 && op <= 14) begin
      if (!mdu_on) begin
        e.res = '0;
        e.ill = 1'b1;
      end else if (op == 10 || !special) begin
        e.lat = 33;
      end
    end
    return e;
  endfunction

  // Presents one request (DUT must be idle) and records its expected outcome.
  task automatic drive(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    in_op = op; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    sb.push_back(model(name, op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_illegal !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b res=%h ill=%b rdy=%b, want 0/0/0/1",
               out_valid, out_result, out_illegal, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_simple();
    int lat;
    exp_t e;
    logic [3:0] ops[10] = '{0, 1, 7, 4, 2, 3, 5, 6, 8, 9};
    logic [31:0] as[10] = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'h1, 32'h0000_00F1,
                            32'hFFFF_FFF0, 32'hA5A5_0F0F, 32'hF000_0001, 32'h1200_0034, 32'hDEAD_BEEF};
    logic [31:0] bs[10] = '{32'h1, 32'h1, 32'd31, 32'hFFFF_FFFF, 32'h0000_0024,
                            32'h0000_0002, 32'h5A5A_FFFF, 32'h0000_0104, 32'h0056_0078, 32'h0F0F_F0F0};
    for (int i = 0; i < 10; i++) begin
      drive($sformatf("simple%0d_op%0d", i, ops[i]), ops[i], as[i], bs[i]);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_illegal !== e.ill || lat != e.lat) begin
        errors++;
        $display("FAIL %s: valid=%b res=%h ill=%b lat=%0d, want res=%h ill=%b lat=%0d",
                 e.name, out_valid, out_result, out_illegal, lat, e.res, e.ill, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mdu();
    int lat;
    exp_t e;
    logic busy_bad;
    logic [3:0] ops[7] = '{10, 11, 13, 12, 14, 11, 13};
    logic [31:0] as[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1000,
                           32'd1000, 32'd100, 32'h8000_0000};
    logic [31:0] bs[7] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'd3};
    for (int i = 0; i < 7; i++) begin
      drive($sformatf("mdu%0d_op%0d", i, ops[i]), ops[i], as[i], bs[i]);
      busy_bad = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
        if (in_ready !== 1'b0) busy_bad = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_illegal !== e.ill || lat != e.lat || busy_bad) begin
        errors++;
        $display("FAIL %s: valid=%b res=%h ill=%b lat=%0d busy_rdy=%b, want res=%h ill=%b lat=%0d busy_rdy=0",
                 e.name, out_valid, out_result, out_illegal, lat, busy_bad, e.res, e.ill, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_special();
    int lat;
    exp_t e;
    logic [3:0] ops[5] = '{12, 11, 13, 14, 13};
    logic [31:0] as[5] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FF00};
    logic [31:0] bs[5] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      drive($sformatf("divspec%0d_op%0d", i, ops[i]), ops[i], as[i], bs[i]);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_illegal !== e.ill || lat != e.lat) begin
        errors++;
        $display("FAIL %s: valid=%b res=%h ill=%b lat=%0d, want res=%h ill=%b lat=%0d",
                 e.name, out_valid, out_result, out_illegal, lat, e.res, e.ill, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    logic [31:0] held;
    out_ready = 1'b0;
    drive("bp_xor", 4'd5, 32'hCAFE_0000, 32'h0000_BABE);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_result !== e.res || lat != e.lat) begin
      errors++;
      $display("FAIL %s: valid=%b res=%h lat=%0d, want res=%h lat=%0d",
               e.name, out_valid, out_result, lat, e.res, e.lat);
    end
    held = e.res;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b res=%h rdy=%b, want valid=1 res=%h rdy=0",
                 i, out_valid, out_result, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b valid=%b, want rdy=1 valid=0", in_ready, out_valid);
    end
    drive("bp_next_and", 4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_result !== e.res || out_illegal !== e.ill || lat != e.lat) begin
      errors++;
      $display("FAIL %s: valid=%b res=%h ill=%b lat=%0d, want res=%h ill=%b lat=%0d",
               e.name, out_valid, out_result, out_illegal, lat, e.res, e.ill, e.lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    int lat;
    exp_t e;
    logic seen;
`ifdef YSYX_25060173_ALU_MDU_EN
    drive("flush_mul", 4'd10, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: valid=%b rdy=%b, want valid=0 rdy=1", out_valid, in_ready);
    end
    void'(sb.pop_front());
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid seen=%b, want 0", seen);
    end
`endif
    out_ready = 1'b0;
    drive("flush_done_add", 4'd0, 32'd9, 32'd9);
    wait_out(lat);
    void'(sb.pop_front());
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: valid=%b rdy=%b, want valid=0 rdy=1", out_valid, in_ready);
    end
    in_op = 4'd0; in_src1 = 32'd1; in_src2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_rdy_report: rdy=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_blocks_accept: valid=%b rdy=%b, want valid=0 rdy=1", out_valid, in_ready);
    end
    drive("flush_after_add", 4'd0, 32'd2, 32'd3);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd5 || out_illegal !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL %s: valid=%b res=%h ill=%b lat=%0d, want res=%h ill=0 lat=1",
               e.name, out_valid, out_result, out_illegal, lat, e.res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    int lat;
    exp_t e;
    logic [3:0] ops[2] = '{15, 10};
    for (int i = 0; i < 2; i++) begin
      drive($sformatf("illegal_op%0d", ops[i]), ops[i], 32'h1111_2222, 32'h3);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_illegal !== e.ill || lat != e.lat) begin
        errors++;
        $display("FAIL %s: valid=%b res=%h ill=%b lat=%0d, want res=%h ill=%b lat=%0d",
                 e.name, out_valid, out_result, out_illegal, lat, e.res, e.ill, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_busy();
`ifdef YSYX_25060173_ALU_MDU_EN
    logic seen;
    drive("rst_mul", 4'd10, 32'd77, 32'd88);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy: valid=%b rdy=%b res=%h, want 0/1/0", out_valid, in_ready, out_result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_no_result: out_valid seen=%b, want 0", seen);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      drive($sformatf("b2b%0d_op%0d", i, op), op, a, b);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_result !== e.res || out_illegal !== e.ill || lat != e.lat) begin
        errors++;
        $display("FAIL %s: a=%h b=%h valid=%b res=%h ill=%b lat=%0d, want res=%h ill=%b lat=%0d",
                 e.name, a, b, out_valid, out_result, out_illegal, lat, e.res, e.ill, e.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_simple();
`ifdef YSYX_25060173_ALU_MDU_EN
    test_mdu();
`endif
    test_div_special();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25060173_alu_seq.md
Name: ysyx_25060173_alu_seq

Overview:
Parametrised successor to the single-op execute ALU. It is XLEN-wide and covers the full RV integer ALU op set plus iterative multiply/divide.
- Simple ops are registered with 1-cycle latency.
- MUL/DIV/REM run over multiple cycles on a shared shift/add datapath.
- It sits in the EXU between decode operand select and writeback, using a valid/ready handshake on both sides.

Parameters:
XLEN, 32, operand/result width (power of two, 8..64)
OPW, 4, op-code width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  abort any in-flight op, return to IDLE
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_op  in  OPW  op code
in_src1  in  XLEN  operand A
in_src2  in  XLEN  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  XLEN  result
out_illegal  out  1  op not supported (reserved code, or MDU op with MDU compiled out)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). On reset assertion: state=IDLE, out_valid=0, out_result=0, out_illegal=0, counter=0, all datapath regs cleared.
- Op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 MUL (low XLEN bits), 11 DIV, 12 DIVU, 13 REM, 14 REMU.
  - 15 reserved.
- Shift amount is in_src2[$clog2(XLEN)-1:0]. SLT/SLTU return a zero-extended 1/0. All arithmetic is modulo 2^XLEN.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE). Accept = in_valid & in_ready.
- IDLE on accept:
  - Simple op, reserved op, or divide special case: result is computed combinationally and registered; next state DONE. out_valid rises the cycle after accept.
  - MUL/DIV/REM: operands are latched (divide operands converted to magnitudes, with result sign recorded); counter=XLEN; next state BUSY.
- BUSY: one iteration per cycle.
  - MUL: shift-add on multiplier LSB.
  - DIV: restoring subtract, one quotient bit per cycle.
  - The counter decrements each cycle. At counter==1 the sign fix-up is applied, the result is registered, and the FSM goes to DONE.
  - Total latency from accept to out_valid: XLEN+1 cycles.
- DONE: out_valid=1. out_result and out_illegal are held stable until out_ready. On out_valid & out_ready the FSM goes to IDLE, so a new request can be accepted the following cycle (no same-cycle turnaround).
- Divide special cases (1-cycle path):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return src1.
  - Signed overflow (src1 = most-negative, src2 = -1): DIV returns src1; REM returns 0.
- Reserved op: out_result=0, out_illegal=1, 1-cycle path.
- flush:
  - Forces IDLE from any state and drops out_valid the next cycle. flush has priority over accept and over out handshake.
  - A request presented in the same cycle as flush is not accepted; in_ready is still reported as (state==IDLE).
- Reset mid-BUSY: the operation is discarded; no out_valid is produced.

Optional Feature:
- YSYX_25060173_ALU_MDU_EN defined: ops 10-14 are implemented as above.
- Undefined: no multiply/divide datapath or counter is synthesised. Ops 10-14 are treated as reserved (1-cycle, result 0, out_illegal=1). The FSM never enters BUSY.

Decomposition:
- Shared package: op-code localparams (ALU_OP_ADD..ALU_OP_REMU), OPW, FSM state encoding.
- One sub-module, ysyx_25060173_mdu_iter. It holds the iterative multiply/divide datapath and counter, with start/done strobes and a flush input. It is instantiated only under the macro.
- The simple-op combinational path stays in the top module.

Test Plan:
- ADD 0x7FFFFFFF+1 → 0x80000000 one cycle after accept. SUB 0-1 → 0xFFFFFFFF. SRA 0x80000000>>>31 → 0xFFFFFFFF. SLTU 1<0xFFFFFFFF → 1.
- MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001. out_valid exactly 33 cycles after accept. in_ready=0 throughout BUSY.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF; DIV 0x80000000/-1 → 0x80000000 with 1-cycle latency.
- Backpressure: out_ready low 5 cycles in DONE → result stable, in_ready=0. Release → new op accepted the next cycle.
- flush at BUSY cycle 10 → no out_valid, in_ready=1 the next cycle. A following ADD 2+3 → 5.
- Op 15 → out_illegal=1, result 0. With the macro undefined, op 10 → out_illegal=1 in 1 cycle.
